// File: rtl/bus_pkg.sv
// Shared definitions for the bus source selector / arbiter.
//   state_t     : FSM encodings for the round-robin controller
//   MODE_*      : values of the mode input
//   clog2       : constant-evaluable ceil(log2(n)) used for index widths
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWNED  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search.
//   req        : per-source request vector
//   ptr        : index of the most recent winner; search starts at ptr+1
//   found      : at least one request is set
//   winner_idx : binary index of the first set request after ptr (mod N_SRC)
//   winner_oh  : one-hot form of winner_idx, zero when nothing is found
module rr_arbiter #(
  parameter int N_SRC = 8,
  parameter int SEL_W = 3
) (
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] winner_idx,
  output logic [N_SRC-1:0] winner_oh
);

  // One extra bit so ptr+i never overflows before the modulo fold;
  // the fold keeps non-power-of-two sizes inside 0..N_SRC-1.
  logic [SEL_W:0] cand;

  always_comb begin
    found      = 1'b0;
    winner_idx = '0;
    winner_oh  = '0;
    cand       = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      cand = {1'b0, ptr} + (SEL_W+1)'(i);
      if (cand >= (SEL_W+1)'(N_SRC)) cand = cand - (SEL_W+1)'(N_SRC);
      if (!found && req[cand[SEL_W-1:0]]) begin
        found      = 1'b1;
        winner_idx = cand[SEL_W-1:0];
      end
    end
    winner_oh[winner_idx] = found;
  end

endmodule

// File: rtl/bus_arb_mux.sv
// Registered common-bus source selector with direct-select and
// round-robin (optionally locked) arbitration modes.
//   clk, rst   : clock, asynchronous active-high reset
//   mode       : 0 direct select via sel, 1 round-robin over req
//   sel        : source index for direct select
//   d          : flattened source data, source i at d[i*WIDTH +: WIDTH]
//   req, lock  : round-robin requests and owner bus lock
//   out        : registered bus value
//   out_valid  : out carries data from a granted source
//   grant      : one-hot owner, zero when the bus is free
//   grant_idx  : binary owner index, holds when grant is zero
//
// state     | meaning
// ST_IDLE   | nobody owns the bus (also forced while in direct mode)
// ST_OWNED  | one-cycle tenure, re-arbitrate every cycle
// ST_LOCKED | owner keeps the bus while lock and its req stay high
module bus_arb_mux
  import bus_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int N_SRC = 8,
  localparam int SEL_W = clog2(N_SRC)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_SRC*WIDTH-1:0] d,
  input  logic [N_SRC-1:0]       req,
  input  logic                   lock,
  output logic [WIDTH-1:0]       out,
  output logic                   out_valid,
  output logic [N_SRC-1:0]       grant,
  output logic [SEL_W-1:0]       grant_idx
);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic             arb_found;
  logic [SEL_W-1:0] arb_idx;
  logic [N_SRC-1:0] arb_oh;
  logic             sel_ok;
  logic             hold;
  logic [WIDTH-1:0] src [N_SRC];

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    assign src[g] = d[g*WIDTH +: WIDTH];
  end

  // sel can address past the last source when N_SRC is not a power of two.
  assign sel_ok = ({1'b0, sel} < (SEL_W+1)'(N_SRC));
  // grant_idx is the owner index whenever the FSM is in LOCKED.
  assign hold   = (state == ST_LOCKED) && lock && req[grant_idx];

  rr_arbiter #(
    .N_SRC (N_SRC),
    .SEL_W (SEL_W)
  ) u_arb (
    .req        (req),
    .ptr        (ptr),
    .found      (arb_found),
    .winner_idx (arb_idx),
    .winner_oh  (arb_oh)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      grant     <= '0;
      grant_idx <= '0;
      ptr       <= SEL_W'(N_SRC - 1);
      state     <= ST_IDLE;
    end else if (mode == MODE_DIRECT) begin
      state <= ST_IDLE;
      if (sel_ok) begin
        out       <= src[sel];
        grant     <= {{(N_SRC-1){1'b0}}, 1'b1} << sel;
        grant_idx <= sel;
        out_valid <= 1'b1;
      end else begin
        out       <= '0;
        grant     <= '0;
        out_valid <= 1'b0;
      end
    end else if (hold) begin
      out       <= src[grant_idx];
      out_valid <= 1'b1;
    end else if (arb_found) begin
      // IDLE, OWNED and a released LOCKED all arbitrate the same way.
      grant     <= arb_oh;
      grant_idx <= arb_idx;
      ptr       <= arb_idx;
      out       <= src[arb_idx];
      out_valid <= 1'b1;
      state     <= lock ? ST_LOCKED : ST_OWNED;
    end else begin
      grant     <= '0;
      out_valid <= 1'b0;
      state     <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_bus_arb_mux.sv
module tb_bus_arb_mux;
  import bus_pkg::*;

  typedef struct {
    string       name;
    logic [19:0] v;
  } exp_t;

  logic        clk;
  logic        rst;

  logic        mode8, lock8;
  logic [2:0]  sel8;
  logic [63:0] d8;
  logic [7:0]  req8;
  logic [7:0]  out8;
  logic        valid8;
  logic [7:0]  grant8;
  logic [2:0]  idx8;

  logic        mode5, lock5;
  logic [2:0]  sel5;
  logic [39:0] d5;
  logic [4:0]  req5;
  logic [7:0]  out5;
  logic        valid5;
  logic [4:0]  grant5;
  logic [2:0]  idx5;

  exp_t sb[$];
  exp_t e;
  int   n_checks;
  int   n_errors;

  bus_arb_mux #(.WIDTH(8), .N_SRC(8)) dut8 (
    .clk(clk), .rst(rst), .mode(mode8), .sel(sel8), .d(d8), .req(req8),
    .lock(lock8), .out(out8), .out_valid(valid8), .grant(grant8),
    .grant_idx(idx8)
  );

  bus_arb_mux #(.WIDTH(8), .N_SRC(5)) dut5 (
    .clk(clk), .rst(rst), .mode(mode5), .sel(sel5), .d(d5), .req(req5),
    .lock(lock5), .out(out5), .out_valid(valid5), .grant(grant5),
    .grant_idx(idx5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [19:0] mk(logic [7:0] o, logic v, logic [7:0] g, logic [2:0] i);
    return {o, v, g, i};
  endfunction

  function automatic logic [19:0] obs8();
    return {out8, valid8, grant8, idx8};
  endfunction

  function automatic logic [19:0] obs5();
    return {out5, valid5, 3'b000, grant5, idx5};
  endfunction

  function automatic logic [7:0] oh8(int k);
    logic [7:0] one;
    one = 8'd1;
    return one << k;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle reset pulse; leaves time at posedge+3, before the next edge.
  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    pulse_rst();
    mode8 = MODE_RR; lock8 = 1'b0; req8 = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{$sformatf("pre_reset_%0d", k), mk(8'h10 + 8'(k), 1'b1, oh8(k), 3'(k))});
      cyc();
      e = sb.pop_front(); n_checks++;
      if (obs8() !== e.v) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h", e.name, obs8(), e.v);
      end
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (obs8() !== mk(8'h00, 1'b0, 8'h00, 3'd0)) begin
      n_errors++;
      $display("FAIL reset_async: got %h expected %h", obs8(), mk(8'h00, 1'b0, 8'h00, 3'd0));
    end
    #1 rst = 1'b0;
    sb.push_back('{"reset_first_grant", mk(8'h10, 1'b1, 8'h01, 3'd0)});
    cyc();
    e = sb.pop_front(); n_checks++;
    if (obs8() !== e.v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", e.name, obs8(), e.v);
    end
  endtask

  task automatic test_direct();
    int sels[4] = '{3, 7, 0, 5};
    pulse_rst();
    mode8 = MODE_DIRECT; lock8 = 1'b1; req8 = 8'hFF;
    foreach (sels[k]) begin
      sel8 = 3'(sels[k]);
      sb.push_back('{$sformatf("direct_sel%0d", sels[k]),
                     mk(8'h10 + 8'(sels[k]), 1'b1, oh8(sels[k]), 3'(sels[k]))});
      cyc();
      e = sb.pop_front(); n_checks++;
      if (obs8() !== e.v) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h", e.name, obs8(), e.v);
      end
    end
  endtask

  task automatic test_fairness();
    pulse_rst();
    mode8 = MODE_RR; lock8 = 1'b0; req8 = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      sb.push_back('{$sformatf("rr_fair_%0d", k), mk(8'h10 + 8'(k % 8), 1'b1, oh8(k % 8), 3'(k % 8))});
      cyc();
      e = sb.pop_front(); n_checks++;
      if (obs8() !== e.v) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h", e.name, obs8(), e.v);
      end
    end
  endtask

  task automatic test_lock();
    // req/lock per cycle and the owner expected after that edge
    logic [7:0] t_req [11] = '{8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h04, 8'h05, 8'h05, 8'h05, 8'h05};
    logic       t_lock[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int         t_idx [11] = '{0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 2};
    pulse_rst();
    mode8 = MODE_RR;
    for (int k = 0; k < 11; k++) begin
      req8 = t_req[k]; lock8 = t_lock[k];
      sb.push_back('{$sformatf("lock_%0d", k), mk(8'h10 + 8'(t_idx[k]), 1'b1, oh8(t_idx[k]), 3'(t_idx[k]))});
      cyc();
      e = sb.pop_front(); n_checks++;
      if (obs8() !== e.v) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h", e.name, obs8(), e.v);
      end
      if (k == 6) begin
        n_checks++;
        if (dut8.state !== ST_LOCKED) begin
          n_errors++;
          $display("FAIL lock_relock_state: got %0d expected %0d", dut8.state, ST_LOCKED);
        end
      end
    end
  endtask

  task automatic test_idle();
    logic [7:0]  t_req[4] = '{8'h10, 8'h00, 8'h00, 8'h10};
    logic [19:0] t_exp[4];
    t_exp[0] = mk(8'h14, 1'b1, 8'h10, 3'd4);
    t_exp[1] = mk(8'h14, 1'b0, 8'h00, 3'd4);
    t_exp[2] = mk(8'h14, 1'b0, 8'h00, 3'd4);
    t_exp[3] = mk(8'h14, 1'b1, 8'h10, 3'd4);
    pulse_rst();
    mode8 = MODE_RR; lock8 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req8 = t_req[k];
      sb.push_back('{$sformatf("idle_%0d", k), t_exp[k]});
      cyc();
      e = sb.pop_front(); n_checks++;
      if (obs8() !== e.v) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h", e.name, obs8(), e.v);
      end
    end
  endtask

  task automatic test_mode_change();
    pulse_rst();
    // lock source 0, detour through direct mode, then come back still asking
    // for a lock: the lock must be gone, so search from ptr=0 finds source 1.
    mode8 = MODE_RR; lock8 = 1'b1; req8 = 8'h01;
    sb.push_back('{"mode_lock0", mk(8'h10, 1'b1, 8'h01, 3'd0)});
    cyc();
    e = sb.pop_front(); n_checks++;
    if (obs8() !== e.v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", e.name, obs8(), e.v);
    end
    mode8 = MODE_DIRECT; sel8 = 3'd5;
    sb.push_back('{"mode_direct5", mk(8'h15, 1'b1, 8'h20, 3'd5)});
    cyc();
    e = sb.pop_front(); n_checks++;
    if (obs8() !== e.v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", e.name, obs8(), e.v);
    end
    mode8 = MODE_RR; req8 = 8'h03;
    sb.push_back('{"mode_back_rr", mk(8'h11, 1'b1, 8'h02, 3'd1)});
    cyc();
    e = sb.pop_front(); n_checks++;
    if (obs8() !== e.v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", e.name, obs8(), e.v);
    end
  endtask

  task automatic test_npot();
    logic        t_mode[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [2:0]  t_sel [7] = '{3'd2, 3'd6, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0};
    logic [19:0] t_exp [7];
    t_exp[0] = mk(8'h12, 1'b1, 8'h04, 3'd2);
    t_exp[1] = mk(8'h00, 1'b0, 8'h00, 3'd2);
    t_exp[2] = mk(8'h00, 1'b0, 8'h00, 3'd2);
    t_exp[3] = mk(8'h10, 1'b1, 8'h01, 3'd0);
    t_exp[4] = mk(8'h14, 1'b1, 8'h10, 3'd4);
    t_exp[5] = mk(8'h10, 1'b1, 8'h01, 3'd0);
    t_exp[6] = mk(8'h14, 1'b1, 8'h10, 3'd4);
    pulse_rst();
    lock5 = 1'b0; req5 = 5'b10001;
    for (int k = 0; k < 7; k++) begin
      mode5 = t_mode[k]; sel5 = t_sel[k];
      sb.push_back('{$sformatf("npot_%0d", k), t_exp[k]});
      cyc();
      e = sb.pop_front(); n_checks++;
      if (obs5() !== e.v) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h", e.name, obs5(), e.v);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    mode8 = 1'b0; lock8 = 1'b0; sel8 = '0; req8 = '0;
    mode5 = 1'b0; lock5 = 1'b0; sel5 = '0; req5 = '0;
    for (int i = 0; i < 8; i++) d8[i*8 +: 8] = 8'h10 + 8'(i);
    for (int i = 0; i < 5; i++) d5[i*8 +: 8] = 8'h10 + 8'(i);
    @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_direct();
    test_fairness();
    test_lock();
    test_idle();
    test_mode_change();
    test_npot();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
